alu_arbiter: RTL and testbench

//  Shares one ALU16 (Control_Unit + datapath) between N requesters. Grants round-robin,

---
 rtl/alu_arbiter.sv | 152 +++++++++++++++
 tb/tb_alu_arbiter.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one ALU16 between N requesters.
// Each request runs IDLE -> ISSUE -> WAIT -> RESP; unsupported opcodes skip straight to RESP.
module alu_arbiter #(
    parameter int unsigned N       = 2,
    parameter int unsigned TIMEOUT = 64,
    parameter logic [15:0] OP_MASK = 16'h00FF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      req,
    input  logic [4*N-1:0]    req_sel,
    input  logic [16*N-1:0]   req_a,
    input  logic [16*N-1:0]   req_b,
    output logic [N-1:0]      gnt,
    output logic [N-1:0]      rsp_valid,
    output logic [31:0]       rsp_data,
    output logic              rsp_err,
    output logic              busy,
    output logic [3:0]        alu_sel,
    output logic [15:0]       alu_a,
    output logic [15:0]       alu_b,
    output logic              alu_start,
    output logic              alu_abort,
    input  logic              alu_finish,
    input  logic [31:0]       alu_result
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   owner;
    logic [TW-1:0]   timer;

    logic            pick_found;
    logic [PW-1:0]   pick_idx;
    logic [3:0]      pick_sel;
    logic [15:0]     pick_a;
    logic [15:0]     pick_b;
    int unsigned     cand;
    logic [N-1:0]    req_sh;
    logic [4*N-1:0]  sel_sh;
    logic [16*N-1:0] a_sh;
    logic [16*N-1:0] b_sh;

    function automatic logic [N-1:0] onehot(input logic [PW-1:0] idx);
        return N'(1) << idx;
    endfunction

    // First requester at or after ptr, wrapping; shifts avoid variable bit-select widths.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        pick_sel   = '0;
        pick_a     = '0;
        pick_b     = '0;
        cand       = 0;
        req_sh     = '0;
        sel_sh     = '0;
        a_sh       = '0;
        b_sh       = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand   = (32'(ptr) + k) % N;
            req_sh = req >> cand;
            sel_sh = req_sel >> (4 * cand);
            a_sh   = req_a >> (16 * cand);
            b_sh   = req_b >> (16 * cand);
            if (!pick_found && req_sh[0]) begin
                pick_found = 1'b1;
                pick_idx   = PW'(cand);
                pick_sel   = sel_sh[3:0];
                pick_a     = a_sh[15:0];
                pick_b     = b_sh[15:0];
            end
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            owner     <= '0;
            timer     <= '0;
            gnt       <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            alu_sel   <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_start <= 1'b0;
            alu_abort <= 1'b0;
        end else begin
            gnt       <= '0;
            rsp_valid <= '0;
            alu_start <= 1'b0;
            alu_abort <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        owner   <= pick_idx;
                        alu_sel <= pick_sel;
                        alu_a   <= pick_a;
                        alu_b   <= pick_b;
                        gnt     <= onehot(pick_idx);
                        if (OP_MASK[pick_sel]) begin
                            alu_start <= 1'b1;
                            state     <= ISSUE;
                        end else begin
                            rsp_valid <= onehot(pick_idx);
                            rsp_err   <= 1'b1;
                            rsp_data  <= '0;
                            state     <= RESP;
                        end
                    end
                end
                ISSUE: begin
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // Abort is registered, so it is decided one count early to land TIMEOUT cycles after start.
                    if (alu_finish) begin
                        rsp_data  <= alu_result;
                        rsp_err   <= 1'b0;
                        rsp_valid <= onehot(owner);
                        state     <= RESP;
                    end else if (timer == TW'(TIMEOUT - 2)) begin
                        alu_abort <= 1'b1;
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= onehot(owner);
                        state     <= RESP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RESP: begin
                    ptr   <= (owner == PW'(N - 1)) ? '0 : owner + 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a per-transaction schedule model predicts every output cycle by cycle,
// driven by directed scenarios followed by random requesters and a random-latency ALU.
module tb_alu_arbiter;

    localparam int          N    = 2;
    localparam int          TO   = 8;
    localparam logic [15:0] MASK = 16'h00FF;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        rq [N];
    logic [3:0]  rs [N];
    logic [15:0] ra [N];
    logic [15:0] rb [N];

    wire  [N-1:0]    req_v;
    wire  [4*N-1:0]  sel_v;
    wire  [16*N-1:0] a_v;
    wire  [16*N-1:0] b_v;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign req_v[g]          = rq[g];
        assign sel_v[4*g +: 4]   = rs[g];
        assign a_v[16*g +: 16]   = ra[g];
        assign b_v[16*g +: 16]   = rb[g];
    end

    logic [N-1:0] gnt, rsp_valid;
    logic [31:0]  rsp_data;
    logic         rsp_err, busy;
    logic [3:0]   alu_sel;
    logic [15:0]  alu_a, alu_b;
    logic         alu_start, alu_abort;
    logic         alu_finish = 1'b0;
    logic [31:0]  alu_result = '0;

    alu_arbiter #(.N(N), .TIMEOUT(TO), .OP_MASK(MASK)) dut (
        .clk(clk), .rst(rst),
        .req(req_v), .req_sel(sel_v), .req_a(a_v), .req_b(b_v),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy), .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b),
        .alu_start(alu_start), .alu_abort(alu_abort),
        .alu_finish(alu_finish), .alu_result(alu_result)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pick_cyc = 0;
    int fin_cyc = -1;
    int lat_next = 2;
    bit auto_req = 0;
    bit lat_rand = 0;
    bit spur_en = 0;

    int unsigned m_ptr = 0;
    logic [3:0]  m_sel = '0;
    logic [15:0] m_a = '0;
    logic [15:0] m_b = '0;

    logic [N-1:0] e_gnt [256];
    logic [N-1:0] e_rv [256];
    logic         e_start [256];
    logic         e_abort [256];
    logic         e_busy [256];
    logic         e_err [256];
    logic [31:0]  e_data [256];

    function automatic logic [7:0] slot(input int x);
        return 8'(x % 256);
    endfunction

    // Reference ALU: signed add/sub/mul on sign-extended operands.
    function automatic logic [31:0] alu_fn(input logic [3:0] s, input logic [15:0] a, input logic [15:0] b);
        logic signed [31:0] sa, sb;
        sa = signed'(a);
        sb = signed'(b);
        case (s)
            4'd0:    return sa + sb;
            4'd1:    return sa - sb;
            4'd2:    return sa * sb;
            default: return {a ^ b, a & b};
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 256; i++) begin
            e_gnt[i] = '0; e_rv[i] = '0; e_start[i] = 0; e_abort[i] = 0;
            e_busy[i] = 0; e_err[i] = 0; e_data[i] = '0;
        end
        m_ptr = 0; m_sel = '0; m_a = '0; m_b = '0;
        fin_cyc = -1;
    endtask

    function automatic int rand_lat();
        int r;
        r = int'($urandom_range(9));
        if (r <= 5) return 1 + int'($urandom_range(3));
        if (r == 6) return TO - 1;
        if (r == 7) return 0;
        if (r == 8) return TO;
        return TO + 1;
    endfunction

    // Transaction-level model: at each decision edge, plan the whole transaction's output timeline.
    task automatic model_edge();
        int o, s, r, lat;
        bit found;
        logic [N-1:0] oh;
        if (cyc != pick_cyc) return;
        found = 0;
        o = 0;
        for (int k = 0; k < N; k++) begin
            int c;
            c = (int'(m_ptr) + k) % N;
            if (!found && rq[c]) begin
                found = 1;
                o = c;
            end
        end
        if (!found) begin
            pick_cyc = cyc + 1;
            return;
        end
        m_sel = rs[o]; m_a = ra[o]; m_b = rb[o];
        oh = N'(1) << o;
        m_ptr = (o + 1) % N;
        if (MASK[m_sel]) begin
            s = cyc + 1;
            e_gnt[slot(s)] = oh;
            e_start[slot(s)] = 1;
            lat = lat_rand ? rand_lat() : lat_next;
            fin_cyc = (lat == 0) ? -1 : s + lat;
            if (lat != 0 && lat <= TO - 1) begin
                r = s + lat + 1;
                e_data[slot(r)] = alu_fn(m_sel, m_a, m_b);
                e_err[slot(r)] = 0;
            end else begin
                r = s + TO;
                e_abort[slot(r)] = 1;
                e_data[slot(r)] = '0;
                e_err[slot(r)] = 1;
            end
        end else begin
            r = cyc + 1;
            e_gnt[slot(r)] = oh;
            e_data[slot(r)] = '0;
            e_err[slot(r)] = 1;
        end
        e_rv[slot(r)] = oh;
        for (int x = cyc + 1; x <= r; x++) e_busy[slot(x)] = 1;
        pick_cyc = r + 1;
    endtask

    task automatic new_op(input int i);
        rs[i] = ($urandom_range(5) == 0) ? 4'(8 + $urandom_range(7)) : 4'($urandom_range(7));
        ra[i] = 16'($urandom);
        rb[i] = 16'($urandom);
    endtask

    task automatic drive_alu();
        alu_finish = 1'b0;
        alu_result = $urandom;
        if (cyc == fin_cyc) begin
            alu_finish = 1'b1;
            alu_result = alu_fn(alu_sel, alu_a, alu_b);
        end else if (spur_en && cyc >= pick_cyc && $urandom_range(3) == 0) begin
            alu_finish = 1'b1;
        end
    endtask

    task automatic drive_req();
        for (int i = 0; i < N; i++) begin
            if (rq[i]) begin
                if (gnt[i]) begin
                    if ($urandom_range(2) == 0) new_op(i);
                    else rq[i] = 1'b0;
                end
            end else if ($urandom_range(3) == 0) begin
                new_op(i);
                rq[i] = 1'b1;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (!rst) model_edge();
        cyc++;
        drive_alu();
        if (auto_req) drive_req();
    endtask

    task automatic settle(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        spur_en = 0;
        for (int i = 0; i < N; i++) rq[i] = 1'b0;
        model_clear();
        step();
        step();
        rst = 1'b0;
        pick_cyc = cyc;
    endtask

    // what: 0 = gnt, 1 = rsp_valid, 2 = alu_abort
    task automatic wait_for(input int what, input string nm, output int n);
        bit hit;
        n = 0;
        hit = 0;
        while (!hit && n < 40) begin
            step();
            n++;
            hit = (what == 0) ? (gnt != '0) : (what == 1) ? (rsp_valid != '0) : alu_abort;
        end
        if (!hit) chk({nm, "_bound"}, 0, 1);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            logic [7:0] k;
            k = slot(cyc);
            chk("gnt", gnt, e_gnt[k]);
            chk("rsp_valid", rsp_valid, e_rv[k]);
            chk("alu_start", alu_start, e_start[k]);
            chk("alu_abort", alu_abort, e_abort[k]);
            chk("busy", busy, e_busy[k]);
            chk("alu_sel", alu_sel, m_sel);
            chk("alu_a", alu_a, m_a);
            chk("alu_b", alu_b, m_b);
            if (e_rv[k] != '0) begin
                chk("rsp_data", rsp_data, e_data[k]);
                chk("rsp_err", rsp_err, e_err[k]);
            end
            e_gnt[k] = '0; e_rv[k] = '0; e_start[k] = 0; e_abort[k] = 0;
            e_busy[k] = 0; e_err[k] = 0; e_data[k] = '0;
        end
    end

    initial begin
        int n;
        for (int i = 0; i < N; i++) begin
            rq[i] = 1'b0; rs[i] = '0; ra[i] = '0; rb[i] = '0;
        end
        do_reset();
        chk("reset_outputs", {gnt, rsp_valid, busy, alu_start, alu_abort, rsp_err}, 0);

        // Single ADD, ALU latency 3
        lat_next = 3;
        rs[0] = 4'd0; ra[0] = 16'd5; rb[0] = 16'd3; rq[0] = 1'b1;
        wait_for(0, "t1_gnt", n);
        chk("t1_gnt_lat", n, 1);
        chk("t1_gnt", gnt, 2'b01);
        chk("t1_start", alu_start, 1);
        rq[0] = 1'b0;
        wait_for(1, "t1_rsp", n);
        chk("t1_rsp_lat", n, 4);
        chk("t1_rsp_valid", rsp_valid, 2'b01);
        chk("t1_data", rsp_data, 32'd8);
        chk("t1_err", rsp_err, 0);
        settle(3);

        // Fairness with both requests held
        do_reset();
        lat_next = 2;
        rs[0] = 4'd0; ra[0] = 16'd1; rb[0] = 16'd2;
        rs[1] = 4'd1; ra[1] = 16'd9; rb[1] = 16'd4;
        rq[0] = 1'b1; rq[1] = 1'b1;
        for (int t = 0; t < 4; t++) begin
            wait_for(0, "t2_gnt", n);
            chk("t2_order", gnt, (t % 2 == 0) ? 2'b01 : 2'b10);
        end
        rq[0] = 1'b0; rq[1] = 1'b0;
        settle(6);

        // Unsupported opcode
        rs[1] = 4'hA; ra[1] = 16'h1234; rb[1] = 16'h5678; rq[1] = 1'b1;
        wait_for(0, "t3_gnt", n);
        chk("t3_gnt", gnt, 2'b10);
        chk("t3_rsp_valid", rsp_valid, 2'b10);
        chk("t3_err", rsp_err, 1);
        chk("t3_data", rsp_data, 0);
        chk("t3_start", alu_start, 0);
        rq[1] = 1'b0;
        settle(3);

        // Timeout, then a normal transaction, then finish on the timeout cycle
        lat_next = 0;
        rs[0] = 4'd0; ra[0] = 16'd7; rb[0] = 16'd9; rq[0] = 1'b1;
        wait_for(0, "t4_gnt", n);
        rq[0] = 1'b0;
        wait_for(2, "t4_abort", n);
        chk("t4_abort_lat", n, TO);
        chk("t4_rsp_valid", rsp_valid, 2'b01);
        chk("t4_err", rsp_err, 1);
        settle(2);
        lat_next = 2;
        rq[0] = 1'b1;
        wait_for(0, "t4b_gnt", n);
        rq[0] = 1'b0;
        wait_for(1, "t4b_rsp", n);
        chk("t4b_err", rsp_err, 0);
        chk("t4b_data", rsp_data, 32'd16);
        settle(2);
        lat_next = TO - 1;
        rq[0] = 1'b1;
        wait_for(0, "t4c_gnt", n);
        rq[0] = 1'b0;
        wait_for(1, "t4c_rsp", n);
        chk("t4c_rsp_lat", n, TO);
        chk("t4c_abort", alu_abort, 0);
        chk("t4c_err", rsp_err, 0);
        settle(2);

        // Async reset two cycles into WAIT
        lat_next = 0;
        rq[0] = 1'b1;
        wait_for(0, "t5_gnt", n);
        rq[0] = 1'b0;
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        chk("t5_ctrl_zero", {gnt, rsp_valid, busy, alu_start, alu_abort, rsp_err, alu_sel}, 0);
        chk("t5_ops_zero", {alu_a, alu_b}, 0);
        chk("t5_data_zero", rsp_data, 0);
        do_reset();
        lat_next = 2;
        rq[0] = 1'b1; rq[1] = 1'b1;
        wait_for(0, "t5_after", n);
        chk("t5_ptr0", gnt, 2'b01);
        rq[0] = 1'b0; rq[1] = 1'b0;
        settle(6);

        // Finish pulses while idle are ignored; SUB and MUL
        repeat (4) begin
            step();
            alu_finish = 1'b1;
            alu_result = 32'hDEAD_BEEF;
        end
        step();
        chk("t6_idle_busy", busy, 0);
        chk("t6_idle_rsp", rsp_valid, 0);
        lat_next = 4;
        rs[0] = 4'd1; ra[0] = 16'd10; rb[0] = 16'd3; rq[0] = 1'b1;
        wait_for(0, "t6_sub_gnt", n);
        rq[0] = 1'b0;
        wait_for(1, "t6_sub_rsp", n);
        chk("t6_sub", rsp_data, 32'd7);
        settle(2);
        rs[0] = 4'd2; ra[0] = 16'd300; rb[0] = 16'hFFFE; rq[0] = 1'b1;
        wait_for(0, "t6_mul_gnt", n);
        rq[0] = 1'b0;
        wait_for(1, "t6_mul_rsp", n);
        chk("t6_mul", rsp_data, 32'hFFFF_FDA8);
        settle(2);

        // Random traffic
        lat_rand = 1;
        spur_en = 1;
        auto_req = 1;
        settle(2000);
        auto_req = 0;
        spur_en = 0;
        for (int i = 0; i < N; i++) rq[i] = 1'b0;
        settle(TO + 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
